// File: rtl/core_mdu.sv
// Iterative RV64 M-extension unit: shift-add multiplier and restoring divider.
// Optional MDU_FAST_PATH_EN lets zero-operand multiplies and special divides skip CALC.
module core_mdu #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   oprd1,
  input  logic [XLEN-1:0]   oprd2,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [CTRL_W-1:0] OP_MUL    = CTRL_W'(5'b10000);
  localparam logic [CTRL_W-1:0] OP_MULH   = CTRL_W'(5'b10001);
  localparam logic [CTRL_W-1:0] OP_MULHSU = CTRL_W'(5'b10011);
  localparam logic [CTRL_W-1:0] OP_DIV    = CTRL_W'(5'b10110);
  localparam logic [CTRL_W-1:0] OP_REM    = CTRL_W'(5'b10101);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                div_q, rem_q, mullo_q, neg_q, spec_q, div0_q;
  logic [XLEN-1:0]     op1_q, b_q, result_q;
  logic [2*XLEN-1:0]   acc_q;

  logic                in_div, in_rem, in_neg, in_div0, in_ovf;
  logic                neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum, div_r, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_d, div_d, acc_d, prod;
  logic [XLEN-1:0]     quo, rmd, final_d;

  function automatic logic [XLEN-1:0] special_res(input logic rem, input logic div0,
                                                  input logic [XLEN-1:0] op1);
    if (div0) special_res = rem ? op1 : '1;
    else      special_res = rem ? '0 : op1;
  endfunction

  always_comb begin
    in_div  = ctrl_i[4] & ctrl_i[2];
    in_rem  = in_div & ctrl_i[0];
    neg1    = oprd1[XLEN-1] & ((ctrl_i == OP_MULH) || (ctrl_i == OP_MULHSU) ||
                               (ctrl_i == OP_DIV)  || (ctrl_i == OP_REM));
    neg2    = oprd2[XLEN-1] & ((ctrl_i == OP_MULH) || (ctrl_i == OP_DIV) ||
                               (ctrl_i == OP_REM));
    mag1    = neg1 ? -oprd1 : oprd1;
    mag2    = neg2 ? -oprd2 : oprd2;
    in_neg  = in_rem ? neg1 : (neg1 ^ neg2);
    in_div0 = (oprd2 == '0);
    in_ovf  = ((ctrl_i == OP_DIV) || (ctrl_i == OP_REM)) &&
              (oprd1 == {1'b1, {(XLEN-1){1'b0}}}) && (oprd2 == '1);
  end

  // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_d    = {mul_sum, acc_q[XLEN-1:1]};
    div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_r - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
    div_d    = {(div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    acc_d    = div_q ? div_d : mul_d;
    prod     = neg_q ? -mul_d : mul_d;
    quo      = div_d[XLEN-1:0];
    rmd      = div_d[2*XLEN-1:XLEN];
    if (!div_q)      final_d = mullo_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (spec_q) final_d = special_res(rem_q, div0_q, op1_q);
    else if (rem_q)  final_d = neg_q ? -rmd : rmd;
    else             final_d = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      mullo_q  <= 1'b0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      div0_q   <= 1'b0;
      op1_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          div_q   <= in_div;
          rem_q   <= in_rem;
          mullo_q <= (ctrl_i == OP_MUL);
          neg_q   <= in_neg;
          spec_q  <= in_div & (in_div0 | in_ovf);
          div0_q  <= in_div0;
          op1_q   <= oprd1;
          cnt_q   <= '0;
          b_q     <= in_div ? mag2 : mag1;
          acc_q   <= {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
          if (!ctrl_i[4]) begin
            state_q  <= DONE;
            result_q <= '0;
          end
`ifdef MDU_FAST_PATH_EN
          else if (in_div ? (in_div0 | in_ovf) : ((oprd1 == '0) || (oprd2 == '0))) begin
            state_q  <= DONE;
            result_q <= in_div ? special_res(in_rem, in_div0, oprd1) : '0;
          end
`endif
          else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            result_q <= final_d;
          end
        end
        DONE: if (resp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign result_o     = result_q;

endmodule

// File: tb/tb_core_mdu.sv
// Self-checking bench for core_mdu: directed literal cases plus randomized ops
// against a plain-arithmetic RISC-V M-extension model.
module tb_core_mdu;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  ctrl_i = '0;
  logic [63:0] oprd1 = '0;
  logic [63:0] oprd2 = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [63:0] result_o;
  logic        busy_o;

  int          checks = 0;
  int          errors = 0;
  logic        exp_active = 1'b0;
  logic [63:0] exp_res = '0;

  core_mdu #(.XLEN(64), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .ctrl_i(ctrl_i), .oprd1(oprd1), .oprd2(oprd2), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN) && (b == '1);
    if (!op[4]) return '0;
    case (op)
      5'b10000: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      5'b10001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      5'b10011: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      5'b10010: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      5'b10110: return (b == 0) ? '1 : ovf ? a : 64'(sa / sb);
      5'b10101: return (b == 0) ? a  : ovf ? '0 : 64'(sa % sb);
      5'b10100: return (b == 0) ? '1 : a / b;
      default:  return (b == 0) ? a  : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!op[4]) return 1;
`ifdef MDU_FAST_PATH_EN
    if (op[2]) begin
      if (b == 0) return 1;
      if ((op == 5'b10110 || op == 5'b10101) && a == MIN && b == '1) return 1;
    end else if (a == 0 || b == 0) return 1;
`endif
    return 65;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Result must match the current transaction whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid_o) begin
        if (exp_active) check("result", result_o, exp_res);
        else            check("spurious_valid", {63'b0, resp_valid_o}, 64'd0);
      end
      check("ready_vs_busy", {63'b0, req_ready_o}, {63'b0, ~busy_o});
    end
  end

  task automatic do_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int hold);
    int cyc;
    @(negedge clk);
    check("ready_before_req", {63'b0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    ctrl_i = op; oprd1 = a; oprd2 = b;
    exp_res = exp;
    exp_active = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    ctrl_i = 5'($urandom); oprd1 = {$urandom, $urandom}; oprd2 = {$urandom, $urandom};
    cyc = 1;
    while (!resp_valid_o && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat(op, a, b)));
    repeat (hold) begin
      @(negedge clk);
      check("hold_busy", {63'b0, busy_o}, 64'd1);
      check("hold_valid", {63'b0, resp_valid_o}, 64'd1);
    end
    @(negedge clk);
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    exp_active = 1'b0;
    check("post_resp_valid", {63'b0, resp_valid_o}, 64'd0);
    check("post_resp_ready", {63'b0, req_ready_o}, 64'd1);
  endtask

  task automatic lit_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] lit, input int hold);
    check("model_pin", model(op, a, b), lit);
    do_op(op, a, b, lit, hold);
  endtask

  task automatic start_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid_i = 1'b1;
    ctrl_i = op; oprd1 = a; oprd2 = b;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  initial begin
    logic [4:0]  op;
    logic [63:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'b0, req_ready_o}, 64'd1);
    check("rst_valid", {63'b0, resp_valid_o}, 64'd0);
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    rst_n = 1'b1;

    lit_op(5'b10001, -64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    lit_op(5'b10000, -64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    lit_op(5'b10010, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    lit_op(5'b10011, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    lit_op(5'b10110, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    lit_op(5'b10101, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    lit_op(5'b10100, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    lit_op(5'b10101, 64'd7, 64'd0, 64'd7, 0);
    lit_op(5'b10110, MIN, '1, MIN, 0);
    lit_op(5'b10101, MIN, '1, 64'd0, 0);
    lit_op(5'b10000, 64'd0, 64'd9, 64'd0, 0);
    lit_op(5'b00011, 64'd5, 64'd6, 64'd0, 0);
    lit_op(5'b10111, 64'd100, 64'd7, 64'd2, 10);

    // Flush mid-divide, then flush racing a request in IDLE.
    start_op(5'b10100, {$urandom, $urandom}, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_valid", {63'b0, resp_valid_o}, 64'd0);
    check("flush_ready", {63'b0, req_ready_o}, 64'd1);
    check("flush_busy", {63'b0, busy_o}, 64'd0);
    repeat (70) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    ctrl_i = 5'b10000; oprd1 = 64'd2; oprd2 = 64'd2;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush_wins_ready", {63'b0, req_ready_o}, 64'd1);
    check("flush_wins_busy", {63'b0, busy_o}, 64'd0);
    lit_op(5'b10000, 64'd6, 64'd7, 64'd42, 0);

    // Reset mid-multiply.
    start_op(5'b10000, 64'd12345, 64'd678);
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", {63'b0, req_ready_o}, 64'd1);
    check("midrst_valid", {63'b0, resp_valid_o}, 64'd0);
    check("midrst_busy", {63'b0, busy_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst_n = 1'b1;
    lit_op(5'b10110, 64'd100, -64'd7, -64'd14, 0);

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 15)) : {2'b10, 3'($urandom)};
      a  = rnd_opnd();
      b  = rnd_opnd();
      do_op(op, a, b, model(op, a, b), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
